// File: rtl/stb_cnt_tracker.sv
// Per-thread store-buffer occupancy tracker: saturating 0..DEPTH counters,
// full/empty decode, overflow/underflow error pulses and high-water marks.
module stb_cnt_tracker #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             st_issue_vld,
  input  logic [1:0]       st_issue_tid,
  input  logic             st_ack_vld,
  input  logic [1:0]       st_ack_tid,
  input  logic [3:0]       stb_ctl_reset,
  input  logic [1:0]       hwm_sel,
  input  logic             hwm_clr,
  output logic [CNT_W-1:0] lsu_ifu_stbcnt0,
  output logic [CNT_W-1:0] lsu_ifu_stbcnt1,
  output logic [CNT_W-1:0] lsu_ifu_stbcnt2,
  output logic [CNT_W-1:0] lsu_ifu_stbcnt3,
  output logic [3:0]       stb_full,
  output logic [3:0]       stb_empty,
  output logic [3:0]       stb_ctl_reset_dly,
  output logic             stb_ovfl_err,
  output logic             stb_undfl_err,
  output logic [1:0]       err_tid,
  output logic [CNT_W-1:0] hwm_out
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [3:0][CNT_W-1:0] cnt_reg;
  logic [3:0][CNT_W-1:0] cnt_next;
  logic [3:0][CNT_W-1:0] hwm_reg;
  logic [3:0][CNT_W-1:0] hwm_next;
  logic [3:0]            ovfl_hit;
  logic [3:0]            undfl_hit;
  logic [3:0]            ctl_dly_reg;
  logic                  ovfl_reg;
  logic                  undfl_reg;
  logic [1:0]            err_tid_reg;
  logic [1:0]            err_tid_next;

  for (genvar gi = 0; gi < 4; gi++) begin : g_thr
    localparam logic [1:0] TID = 2'(gi);
    logic             inc;
    logic             dec;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] nxt;

    assign cnt = cnt_reg[gi];
    assign inc = st_issue_vld && (st_issue_tid == TID);
    assign dec = st_ack_vld && (st_ack_tid == TID);

    // A simultaneous issue and ack cancel, so only a lone event can move or saturate.
    assign nxt = stb_ctl_reset[gi]                    ? '0 :
                 (inc && !dec && cnt < FULL_CNT)      ? cnt + CNT_W'(1) :
                 (dec && !inc && cnt != '0)           ? cnt - CNT_W'(1) :
                 cnt;

    assign ovfl_hit[gi]  = !stb_ctl_reset[gi] && inc && !dec && (cnt >= FULL_CNT);
    assign undfl_hit[gi] = !stb_ctl_reset[gi] && dec && !inc && (cnt == '0);
    assign cnt_next[gi]  = nxt;

    // Clearing reloads the mark with the thread's upcoming count rather than zero.
    assign hwm_next[gi] = ((hwm_clr && hwm_sel == TID) || (nxt > hwm_reg[gi])) ? nxt : hwm_reg[gi];

    assign stb_full[gi]  = (cnt == FULL_CNT);
    assign stb_empty[gi] = (cnt == '0);
  end

  // Overflow wins the shared thread id when both errors fire together.
  always_comb begin
    err_tid_next = err_tid_reg;
    if (|undfl_hit) err_tid_next = st_ack_tid;
    if (|ovfl_hit)  err_tid_next = st_issue_tid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg     <= '0;
      hwm_reg     <= '0;
      ctl_dly_reg <= '0;
      ovfl_reg    <= 1'b0;
      undfl_reg   <= 1'b0;
      err_tid_reg <= '0;
    end else begin
      cnt_reg     <= cnt_next;
      hwm_reg     <= hwm_next;
      ctl_dly_reg <= stb_ctl_reset;
      ovfl_reg    <= |ovfl_hit;
      undfl_reg   <= |undfl_hit;
      err_tid_reg <= err_tid_next;
    end
  end

  assign lsu_ifu_stbcnt0   = cnt_reg[0];
  assign lsu_ifu_stbcnt1   = cnt_reg[1];
  assign lsu_ifu_stbcnt2   = cnt_reg[2];
  assign lsu_ifu_stbcnt3   = cnt_reg[3];
  assign stb_ctl_reset_dly = ctl_dly_reg;
  assign stb_ovfl_err      = ovfl_reg;
  assign stb_undfl_err     = undfl_reg;
  assign err_tid           = err_tid_reg;
  assign hwm_out           = hwm_reg[hwm_sel];

endmodule

// File: tb/tb_stb_cnt_tracker.sv
// Bench for stb_cnt_tracker: hand-derived vector table, a reset-mid-stream
// sequence, then random traffic against a clamp-arithmetic reference model.
module tb_stb_cnt_tracker;

  localparam int DEPTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             st_issue_vld;
  logic [1:0]       st_issue_tid;
  logic             st_ack_vld;
  logic [1:0]       st_ack_tid;
  logic [3:0]       stb_ctl_reset;
  logic [1:0]       hwm_sel;
  logic             hwm_clr;
  logic [CNT_W-1:0] lsu_ifu_stbcnt0, lsu_ifu_stbcnt1, lsu_ifu_stbcnt2, lsu_ifu_stbcnt3;
  logic [3:0]       stb_full, stb_empty, stb_ctl_reset_dly;
  logic             stb_ovfl_err, stb_undfl_err;
  logic [1:0]       err_tid;
  logic [CNT_W-1:0] hwm_out;

  int checks = 0;
  int errors = 0;

  stb_cnt_tracker #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .st_issue_vld(st_issue_vld), .st_issue_tid(st_issue_tid),
    .st_ack_vld(st_ack_vld), .st_ack_tid(st_ack_tid),
    .stb_ctl_reset(stb_ctl_reset), .hwm_sel(hwm_sel), .hwm_clr(hwm_clr),
    .lsu_ifu_stbcnt0(lsu_ifu_stbcnt0), .lsu_ifu_stbcnt1(lsu_ifu_stbcnt1),
    .lsu_ifu_stbcnt2(lsu_ifu_stbcnt2), .lsu_ifu_stbcnt3(lsu_ifu_stbcnt3),
    .stb_full(stb_full), .stb_empty(stb_empty), .stb_ctl_reset_dly(stb_ctl_reset_dly),
    .stb_ovfl_err(stb_ovfl_err), .stb_undfl_err(stb_undfl_err),
    .err_tid(err_tid), .hwm_out(hwm_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [1:0] it;
    logic       av;
    logic [1:0] at;
    logic [3:0] ctl;
    logic [1:0] sel;
    logic       clr;
    int         c[4];
    int         ov;
    int         un;
    int         etid;
    int         hwm;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int iv, input int it, input int av, input int at, input int ctl,
                     input int sel, input int clr, input int c0, input int c1, input int c2,
                     input int c3, input int ov, input int un, input int etid, input int hwm);
    vec_t v;
    v.iv = 1'(iv); v.it = 2'(it); v.av = 1'(av); v.at = 2'(at);
    v.ctl = 4'(ctl); v.sel = 2'(sel); v.clr = 1'(clr);
    v.c[0] = c0; v.c[1] = c1; v.c[2] = c2; v.c[3] = c3;
    v.ov = ov; v.un = un; v.etid = etid; v.hwm = hwm;
    vecs.push_back(v);
  endtask

  task automatic check(input string tag, input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s %s: got %0d expected %0d", tag, name, act, exp);
    end
  endtask

  // Full/empty are derived here from the expected counts rather than read back.
  task automatic check_all(input string tag, input int c[4], input int dly, input int ov,
                           input int un, input int etid, input int hwm);
    int full_e, empty_e;
    full_e = 0; empty_e = 0;
    for (int t = 0; t < 4; t++) begin
      if (c[t] == DEPTH) full_e |= (1 << t);
      if (c[t] == 0)     empty_e |= (1 << t);
    end
    check(tag, "cnt0", int'(lsu_ifu_stbcnt0), c[0]);
    check(tag, "cnt1", int'(lsu_ifu_stbcnt1), c[1]);
    check(tag, "cnt2", int'(lsu_ifu_stbcnt2), c[2]);
    check(tag, "cnt3", int'(lsu_ifu_stbcnt3), c[3]);
    check(tag, "full", int'(stb_full), full_e);
    check(tag, "empty", int'(stb_empty), empty_e);
    check(tag, "ctl_dly", int'(stb_ctl_reset_dly), dly);
    check(tag, "ovfl", int'(stb_ovfl_err), ov);
    check(tag, "undfl", int'(stb_undfl_err), un);
    check(tag, "err_tid", int'(err_tid), etid);
    check(tag, "hwm_out", int'(hwm_out), hwm);
  endtask

  task automatic idle_inputs();
    st_issue_vld = 0; st_issue_tid = 0; st_ack_vld = 0; st_ack_tid = 0;
    stb_ctl_reset = 0; hwm_sel = 0; hwm_clr = 0;
  endtask

  // Reference model state for the random phase.
  int m_cnt[4];
  int m_hwm[4];
  int m_ov, m_un, m_etid, m_dly;

  task automatic model_reset();
    for (int t = 0; t < 4; t++) begin m_cnt[t] = 0; m_hwm[t] = 0; end
    m_ov = 0; m_un = 0; m_etid = 0; m_dly = 0;
  endtask

  task automatic model_step(input int iv, input int it, input int av, input int at,
                            input int ctl, input int sel, input int clr);
    int ov_tid, un_tid;
    ov_tid = -1; un_tid = -1;
    for (int t = 0; t < 4; t++) begin
      int want;
      if (ctl[t]) begin
        m_cnt[t] = 0;
      end else begin
        want = m_cnt[t] + ((iv && it == t) ? 1 : 0) - ((av && at == t) ? 1 : 0);
        if (want > DEPTH) begin want = DEPTH; ov_tid = t; end
        if (want < 0)     begin want = 0;     un_tid = t; end
        m_cnt[t] = want;
      end
      if (clr && sel == t) m_hwm[t] = m_cnt[t];
      else if (m_cnt[t] > m_hwm[t]) m_hwm[t] = m_cnt[t];
    end
    m_ov = (ov_tid >= 0);
    m_un = (un_tid >= 0);
    if (ov_tid >= 0) m_etid = ov_tid;
    else if (un_tid >= 0) m_etid = un_tid;
    m_dly = ctl;
  endtask

  initial begin
    int zeros[4];
    string tag;
    for (int t = 0; t < 4; t++) zeros[t] = 0;

    // Vector table, applied from a freshly reset state.
    for (int i = 1; i <= 3; i++) add(1,2,0,0,0, 2,0, 0,0,i,0, 0,0,0,i);
    for (int i = 1; i <= 8; i++) add(1,0,0,0,0, 0,0, i,0,3,0, 0,0,0,i);
    add(1,0,0,0,0, 0,0, 8,0,3,0, 1,0,0,8);
    add(0,0,0,0,0, 0,0, 8,0,3,0, 0,0,0,8);
    for (int i = 1; i <= 8; i++) add(1,1,0,0,0, 1,0, 8,i,3,0, 0,0,0,i);
    add(1,1,1,1,0, 1,0, 8,8,3,0, 0,0,0,8);
    add(1,3,1,3,0, 3,0, 8,8,3,0, 0,0,0,0);
    for (int i = 7; i >= 0; i--) add(0,0,1,1,0, 1,0, 8,i,3,0, 0,0,0,8);
    add(1,0,1,1,0, 1,0, 8,0,3,0, 1,1,0,8);
    add(0,0,1,1,0, 1,0, 8,0,3,0, 0,1,1,8);
    add(0,0,0,0,0, 1,0, 8,0,3,0, 0,0,1,8);
    add(1,2,0,0,0, 2,0, 8,0,4,0, 0,0,1,4);
    add(1,2,0,0,0, 2,0, 8,0,5,0, 0,0,1,5);
    add(1,2,0,0,4, 2,0, 8,0,0,0, 0,0,1,5);
    add(0,0,0,0,0, 2,0, 8,0,0,0, 0,0,1,5);
    for (int i = 1; i <= 6; i++) add(1,3,0,0,0, 3,0, 8,0,0,i, 0,0,1,i);
    for (int i = 5; i >= 2; i--) add(0,0,1,3,0, 3,0, 8,0,0,i, 0,0,1,6);
    add(0,0,0,0,0, 3,1, 8,0,0,2, 0,0,1,2);
    add(0,0,0,0,0, 3,0, 8,0,0,2, 0,0,1,2);
    add(1,3,0,0,0, 3,1, 8,0,0,3, 0,0,1,3);
    add(1,0,0,0,1, 0,0, 0,0,0,3, 0,0,1,8);
    add(0,0,0,0,0, 0,0, 0,0,0,3, 0,0,1,8);

    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", zeros, 0, 0, 0, 0, 0);
    $display("reset: counts 0, empty=%h", stb_empty);
    rst = 0;

    foreach (vecs[i]) begin
      st_issue_vld = vecs[i].iv; st_issue_tid = vecs[i].it;
      st_ack_vld = vecs[i].av;   st_ack_tid = vecs[i].at;
      stb_ctl_reset = vecs[i].ctl; hwm_sel = vecs[i].sel; hwm_clr = vecs[i].clr;
      @(posedge clk);
      #1;
      tag = $sformatf("vec%0d", i);
      check_all(tag, vecs[i].c, int'(vecs[i].ctl), vecs[i].ov, vecs[i].un, vecs[i].etid, vecs[i].hwm);
      $display("%s: cnt=%0d/%0d/%0d/%0d ovfl=%0d undfl=%0d err_tid=%0d hwm=%0d", tag,
               lsu_ifu_stbcnt0, lsu_ifu_stbcnt1, lsu_ifu_stbcnt2, lsu_ifu_stbcnt3,
               stb_ovfl_err, stb_undfl_err, err_tid, hwm_out);
    end

    // Reset mid-stream with an overflowing issue and an underflowing ack pending.
    st_issue_vld = 1; st_issue_tid = 3; st_ack_vld = 1; st_ack_tid = 1;
    stb_ctl_reset = 4'b0010; hwm_sel = 3; hwm_clr = 0;
    rst = 1;
    @(posedge clk);
    #1;
    check_all("midrst", zeros, 0, 0, 0, 0, 0);
    $display("midrst: cnt3=%0d hwm=%0d ovfl=%0d undfl=%0d", lsu_ifu_stbcnt3, hwm_out,
             stb_ovfl_err, stb_undfl_err);
    rst = 0;
    idle_inputs();
    @(posedge clk);
    #1;
    check_all("postrst", zeros, 0, 0, 0, 0, 0);
    $display("postrst: counts 0 hwm=%0d", hwm_out);

    // Random traffic, issue-heavy so buffers reach full, against the model.
    model_reset();
    for (int n = 0; n < 600; n++) begin
      int iv, it, av, at, ctl, sel, clr, r;
      r   = ($urandom_range(0, 79) == 0);
      iv  = ($urandom_range(0, 9) < 6);
      it  = $urandom_range(0, 3);
      av  = ($urandom_range(0, 9) < ((n % 200) < 100 ? 3 : 7));
      at  = $urandom_range(0, 3);
      ctl = ($urandom_range(0, 19) == 0) ? $urandom_range(1, 15) : 0;
      sel = $urandom_range(0, 3);
      clr = ($urandom_range(0, 9) == 0);
      rst = 1'(r);
      st_issue_vld = 1'(iv); st_issue_tid = 2'(it);
      st_ack_vld = 1'(av);   st_ack_tid = 2'(at);
      stb_ctl_reset = 4'(ctl); hwm_sel = 2'(sel); hwm_clr = 1'(clr);
      @(posedge clk);
      #1;
      if (r) model_reset();
      else   model_step(iv, it, av, at, ctl, sel, clr);
      tag = $sformatf("rnd%0d", n);
      check_all(tag, m_cnt, m_dly, m_ov, m_un, m_etid, m_hwm[sel]);
      $display("%s: rst=%0d is=%0d/%0d ack=%0d/%0d ctl=%h cnt=%0d/%0d/%0d/%0d", tag, r, iv, it,
               av, at, ctl, m_cnt[0], m_cnt[1], m_cnt[2], m_cnt[3]);
    end
    rst = 0;
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stb_cnt_tracker.md
Name: stb_cnt_tracker

Overview:
Per-thread store-buffer occupancy tracker for one core. It is the producer of the 4-bit store-buffer counts that the IFU consumes and that the overflow checker reads.
- Increments a thread's count when the LSU issues a store into that thread's buffer.
- Decrements it on the store's L2 ack/drain.
- Clears it on a per-thread store-buffer control reset.
- Provides full/empty status, saturation error pulses and a per-thread high-water mark for debug.

Parameters:
DEPTH, 8, store-buffer entries per thread (max legal count)
CNT_W, 4, count width; must hold DEPTH+0 without wrap (DEPTH < 2**CNT_W)

Ports:
clk  input  1  core clock
rst  input  1  synchronous reset, active-high
st_issue_vld  input  1  store written into a store buffer this cycle
st_issue_tid  input  2  thread of issued store
st_ack_vld  input  1  store entry retired/drained this cycle
st_ack_tid  input  2  thread of retired store
stb_ctl_reset  input  4  per-thread store-buffer clear, bit t = thread t
hwm_sel  input  2  thread whose high-water mark is driven on hwm_out
hwm_clr  input  1  clear high-water mark of thread hwm_sel
lsu_ifu_stbcnt0..3  output  CNT_W each  registered occupancy, threads 0..3
stb_full  output  4  bit t = (cnt_t == DEPTH)
stb_empty  output  4  bit t = (cnt_t == 0)
stb_ctl_reset_dly  output  4  stb_ctl_reset registered one cycle
stb_ovfl_err  output  1  one-cycle pulse: issue to a full buffer
stb_undfl_err  output  1  one-cycle pulse: ack to an empty buffer
err_tid  output  2  thread of the most recent error; holds until the next error
hwm_out  output  CNT_W  max count reached by thread hwm_sel since last clear

Behaviour:
- Reset (rst=1 at a clk edge): all counts 0; stb_empty=4'hF; stb_full=0; stb_ctl_reset_dly=0; both error pulses 0; err_tid=0; all HWM registers 0. Reset overrides every other input.
- Per thread t, each clk edge: inc = st_issue_vld & (st_issue_tid==t); dec = st_ack_vld & (st_ack_tid==t).
- Priority, highest first:
  1. stb_ctl_reset[t]=1: cnt_t <= 0. inc/dec for t are ignored. No error for t that cycle.
  2. inc & dec: cnt_t unchanged, no error. Applies at cnt=0 (bypass) and at cnt=DEPTH.
  3. inc only: if cnt_t < DEPTH, cnt_t+1. Else cnt_t stays at DEPTH (saturate) and stb_ovfl_err=1 on the next cycle with err_tid=t.
  4. dec only: if cnt_t > 0, cnt_t-1. Else cnt_t stays 0 and stb_undfl_err=1 on the next cycle with err_tid=t.
- Latency: a count change is visible on lsu_ifu_stbcnt* exactly 1 cycle after the event edge. stb_full/stb_empty are combinational decodes of the registered counts (same cycle as the count).
- Counts never exceed DEPTH and never wrap below 0. Arithmetic is CNT_W wide, unsigned.
- Error pulses last exactly one cycle. At most one issue and one ack occur per cycle, so at most one of ovfl/undfl fires per thread per cycle.
- If ovfl and undfl fire in the same cycle on different threads, both pulses assert and err_tid = the ovfl thread.
- stb_ctl_reset_dly <= stb_ctl_reset each cycle (consumers use it to mask checks during the clear window).
- HWM, per thread: hwm_t <= max(hwm_t, next cnt_t) each cycle.
  - hwm_clr=1 sets hwm[hwm_sel] <= next cnt of that thread (not 0). hwm_clr takes precedence over the max update for the selected thread.
  - stb_ctl_reset does not clear HWM.
- hwm_out = hwm[hwm_sel], combinational mux of the registered values.
- Reset asserted mid-operation: all state returns to reset values on that edge. Events in the same cycle are dropped with no error.

Test Plan:
- Reset then 3 issues to T2 on consecutive cycles -> lsu_ifu_stbcnt2 = 1,2,3 on cycles 1,2,3 after the issues; stb_empty=4'hB; other counts 0.
- 8 issues to T0 then a 9th -> cnt0=8, stb_full[0]=1; the 9th produces a stb_ovfl_err 1-cycle pulse, err_tid=0, cnt0 stays 8.
- At cnt1=8, issue+ack to T1 in the same cycle -> cnt1 stays 8, no error. At cnt3=0, issue+ack T3 -> stays 0, no error.
- Ack to T1 at cnt1=0 -> stb_undfl_err pulse, err_tid=1, cnt1=0. At the same time, issue to full T0 -> both pulses, err_tid=0.
- cnt2=5, assert stb_ctl_reset=4'b0100 with an issue to T2 in the same cycle -> cnt2=0 the next cycle; stb_ctl_reset_dly=4'b0100 one cycle later; no error; hwm[2] stays 5.
- Fill T3 to 6, drain to 2, hwm_sel=3 -> hwm_out=6. Pulse hwm_clr -> hwm_out=2. Then rst mid-stream with a pending issue -> all counts 0, hwm_out=0, no pulses.
